// File: rtl/sd_loader_pkg.sv
// Shared types and defaults for the SD-card frame loader.
package sd_loader_pkg;

    localparam int unsigned NUM_PIXELS_DEF   = 307200;
    localparam int unsigned SECTOR_BYTES_DEF = 512;
    localparam int unsigned FB_ADDR_W        = 19;
    localparam int unsigned PIX_W            = 12;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RDY = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_READ     = 3'd3,
        ST_SECT_END = 3'd4,
        ST_FINISH   = 3'd5
    } state_e;

endpackage

// File: rtl/sd_frame_loader_packer.sv
// Packs a stream of bytes into RGB444 pixels: three bytes make two pixels.
module rgb444_packer
    import sd_loader_pkg::*;
(
    input  logic             clk_25mhz,
    input  logic             reset,
    input  logic             clear,
    input  logic             byte_valid,
    input  logic [7:0]       byte_in,
    output logic             pix_valid_c,
    output logic [PIX_W-1:0] pix_c
);

    logic [1:0] phase_q, phase_d;
    logic [7:0] acc_q, acc_d;

    // acc holds the whole first byte, then only the leftover low nibble
    always_comb begin
        phase_d     = phase_q;
        acc_d       = acc_q;
        pix_valid_c = 1'b0;
        pix_c       = '0;
        if (clear) begin
            phase_d = 2'd0;
            acc_d   = '0;
        end else if (byte_valid) begin
            case (phase_q)
                2'd0: begin
                    acc_d   = byte_in;
                    phase_d = 2'd1;
                end
                2'd1: begin
                    pix_valid_c = 1'b1;
                    pix_c       = {acc_q, byte_in[7:4]};
                    acc_d       = {4'h0, byte_in[3:0]};
                    phase_d     = 2'd2;
                end
                default: begin
                    pix_valid_c = 1'b1;
                    pix_c       = {acc_q[3:0], byte_in};
                    acc_d       = '0;
                    phase_d     = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            phase_q <= 2'd0;
            acc_q   <= '0;
        end else begin
            phase_q <= phase_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: rtl/sd_frame_loader.sv
// Streams consecutive SD sectors into the frame buffer as RGB444 pixels.
module sd_frame_loader
    import sd_loader_pkg::*;
#(
    parameter int unsigned NUM_PIXELS   = NUM_PIXELS_DEF,
    parameter int unsigned SECTOR_BYTES = SECTOR_BYTES_DEF
) (
    input  logic                 clk_25mhz,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          base_addr,
    input  logic                 sd_ready,
    input  logic                 sd_byte_available,
    input  logic [7:0]           sd_dout,
    output logic                 sd_rd,
    output logic [31:0]          sd_addr,
    output logic                 fb_we,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [PIX_W-1:0]     fb_din,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned CNT_W  = FB_ADDR_W + 1;
    localparam int unsigned BYTE_W = $clog2(SECTOR_BYTES) + 1;

    state_e               state_q, state_d;
    logic [31:0]          sd_addr_q, sd_addr_d;
    logic [CNT_W-1:0]     pix_cnt_q, pix_cnt_d;
    logic [BYTE_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic                 bav_q;
    logic                 sd_rd_q, sd_rd_d;
    logic                 fb_we_q, fb_we_d;
    logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [PIX_W-1:0]     fb_din_q, fb_din_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 start_ok_c;
    logic                 capture_c;
    logic                 pix_valid_c;
    logic [PIX_W-1:0]     pix_c;

    assign start_ok_c = start && (state_q == ST_IDLE || state_q == ST_FINISH);
    assign capture_c  = (state_q == ST_READ) && sd_byte_available && !bav_q;

    rgb444_packer u_packer (
        .clk_25mhz   (clk_25mhz),
        .reset       (reset),
        .clear       (start_ok_c),
        .byte_valid  (capture_c),
        .byte_in     (sd_dout),
        .pix_valid_c (pix_valid_c),
        .pix_c       (pix_c)
    );

    always_comb begin
        state_d    = state_q;
        sd_addr_d  = sd_addr_q;
        pix_cnt_d  = pix_cnt_q;
        byte_cnt_d = byte_cnt_q;
        fb_we_d    = 1'b0;
        fb_addr_d  = fb_addr_q;
        fb_din_d   = fb_din_q;

        // pixel counter reflects the write issued last cycle
        if (fb_we_q) begin
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
        end
        if (pix_valid_c && (pix_cnt_d < CNT_W'(NUM_PIXELS))) begin
            fb_we_d   = 1'b1;
            fb_addr_d = pix_cnt_d[FB_ADDR_W-1:0];
            fb_din_d  = pix_c;
        end

        case (state_q)
            ST_IDLE, ST_FINISH: begin
                if (start) begin
                    state_d    = ST_WAIT_RDY;
                    sd_addr_d  = base_addr;
                    pix_cnt_d  = '0;
                    byte_cnt_d = '0;
                end
            end
            ST_WAIT_RDY: begin
                if (sd_ready) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!sd_ready) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (capture_c) begin
                    if (byte_cnt_q == BYTE_W'(SECTOR_BYTES - 1)) begin
                        byte_cnt_d = '0;
                        sd_addr_d  = sd_addr_q + 32'(SECTOR_BYTES);
                        state_d    = ST_SECT_END;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BYTE_W'(1);
                    end
                end
            end
            ST_SECT_END: begin
                state_d = (pix_cnt_d < CNT_W'(NUM_PIXELS)) ? ST_WAIT_RDY : ST_FINISH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        sd_rd_d = (state_d == ST_ISSUE);
        busy_d  = (state_d != ST_IDLE) && (state_d != ST_FINISH);
        done_d  = (state_d == ST_FINISH);
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sd_addr_q  <= '0;
            pix_cnt_q  <= '0;
            byte_cnt_q <= '0;
            bav_q      <= 1'b0;
            sd_rd_q    <= 1'b0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_din_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sd_addr_q  <= sd_addr_d;
            pix_cnt_q  <= pix_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            bav_q      <= sd_byte_available;
            sd_rd_q    <= sd_rd_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_din_q   <= fb_din_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign sd_rd   = sd_rd_q;
    assign sd_addr = sd_addr_q;
    assign fb_we   = fb_we_q;
    assign fb_addr = fb_addr_q;
    assign fb_din  = fb_din_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
